// File: rtl/imem_bus_arbiter.sv
`default_nettype none
// imem_bus_arbiter: arbitrates icache demand and prefetch loads onto one instruction-memory
// bus and tracks tag ownership. Optional starvation guard: define SYS_ARB_STARVE_GUARD_EN.
module imem_bus_arbiter #(
   parameter int SYS_XLEN     = 64,
   parameter int NUM_TAGS     = 16,
   parameter int MAX_PF_OUT   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          dem_cmd,
   input  logic [SYS_XLEN-1:0] dem_addr,
   input  logic [1:0]          pf_cmd,
   input  logic [SYS_XLEN-1:0] pf_addr,
   input  logic [3:0]          mem2arb_response,
   input  logic [3:0]          mem2arb_tag,
   output logic [1:0]          arb2mem_cmd,
   output logic [SYS_XLEN-1:0] arb2mem_addr,
   output logic [3:0]          dem_response,
   output logic [3:0]          pf_response,
   output logic                pf_bus_priority,
   output logic                data_is_dem,
   output logic                data_is_pf,
   output logic [3:0]          pf_outstanding,
   output logic                err_bad_tag
);

   localparam logic [1:0] BUS_NONE = 2'b00;
   localparam logic [3:0] MAX_PF   = 4'(MAX_PF_OUT);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DEM  = 2'd1,
      GNT_PF   = 2'd2
   } grant_t;

   generate
      if (NUM_TAGS < 2 || NUM_TAGS > 16) begin : g_bad_num_tags
         $error("NUM_TAGS must be 2..16 to fit the 4-bit tag ports");
      end
      if (MAX_PF_OUT < 1 || MAX_PF_OUT > NUM_TAGS - 1) begin : g_bad_max_pf
         $error("MAX_PF_OUT must be 1..NUM_TAGS-1");
      end
      if (STARVE_LIMIT < 1) begin : g_bad_starve
         $error("STARVE_LIMIT must be at least 1");
      end
   endgenerate

   logic                dem_valid;
   logic                pf_valid;
   logic                pf_room;
   logic                force_pf;
   logic                accept;
   logic                complete;
   logic                pf_accept;
   logic                pf_complete;
   grant_t              grant;
   logic [NUM_TAGS-1:0] tag_valid;
   logic [NUM_TAGS-1:0] tag_dem;

   assign dem_valid = (dem_cmd != BUS_NONE);
   assign pf_valid  = (pf_cmd != BUS_NONE);
   assign pf_room   = (pf_outstanding < MAX_PF);

`ifdef SYS_ARB_STARVE_GUARD_EN
   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;

   assign force_pf = pf_valid && (starve_cnt == STARVE_MAX) && pf_room;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!pf_valid || grant == GNT_PF) begin
         starve_cnt <= '0;
      end else if (grant == GNT_DEM && starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign force_pf = 1'b0;
`endif

   always_comb begin
      grant = GNT_NONE;
      if (force_pf || (!dem_valid && pf_valid && pf_room)) begin
         grant = GNT_PF;
      end else if (dem_valid) begin
         grant = GNT_DEM;
      end
   end

   always_comb begin
      arb2mem_cmd  = BUS_NONE;
      arb2mem_addr = '0;
      dem_response = 4'd0;
      pf_response  = 4'd0;
      case (grant)
         GNT_DEM: begin
            arb2mem_cmd  = dem_cmd;
            arb2mem_addr = dem_addr;
            dem_response = mem2arb_response;
         end
         GNT_PF: begin
            arb2mem_cmd  = pf_cmd;
            arb2mem_addr = pf_addr;
            pf_response  = mem2arb_response;
         end
         default: ;
      endcase
   end

   assign pf_bus_priority = pf_valid && (grant != GNT_PF);

   assign accept      = (grant != GNT_NONE) && (mem2arb_response != 4'd0);
   assign pf_accept   = accept && (grant == GNT_PF);
   assign complete    = (mem2arb_tag != 4'd0) && tag_valid[mem2arb_tag];
   assign data_is_dem = complete && tag_dem[mem2arb_tag];
   assign data_is_pf  = complete && !tag_dem[mem2arb_tag];
   assign pf_complete = data_is_pf;

   // Allocation is written after the clear so a same-cycle re-accept keeps the entry valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid      <= '0;
         tag_dem        <= '0;
         pf_outstanding <= 4'd0;
         err_bad_tag    <= 1'b0;
      end else begin
         if (complete) begin
            tag_valid[mem2arb_tag] <= 1'b0;
         end
         if (accept) begin
            tag_valid[mem2arb_response] <= 1'b1;
            tag_dem[mem2arb_response]   <= (grant == GNT_DEM);
         end
         if (pf_accept && !pf_complete) begin
            pf_outstanding <= pf_outstanding + 4'd1;
         end else if (!pf_accept && pf_complete) begin
            pf_outstanding <= pf_outstanding - 4'd1;
         end
         if (mem2arb_tag != 4'd0 && !tag_valid[mem2arb_tag]) begin
            err_bad_tag <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_bus_arbiter.sv
`default_nettype none
// tb_imem_bus_arbiter: directed self-checking bench for imem_bus_arbiter.
module tb_imem_bus_arbiter;

   localparam int         XL   = 64;
   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] LOAD = 2'b01;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    dem_cmd = NONE;
   logic [XL-1:0] dem_addr = '0;
   logic [1:0]    pf_cmd = NONE;
   logic [XL-1:0] pf_addr = '0;
   logic [3:0]    mem2arb_response = 4'd0;
   logic [3:0]    mem2arb_tag = 4'd0;
   logic [1:0]    arb2mem_cmd;
   logic [XL-1:0] arb2mem_addr;
   logic [3:0]    dem_response;
   logic [3:0]    pf_response;
   logic          pf_bus_priority;
   logic          data_is_dem;
   logic          data_is_pf;
   logic [3:0]    pf_outstanding;
   logic          err_bad_tag;

   int total = 0;
   int bad   = 0;

   imem_bus_arbiter #(
      .SYS_XLEN(XL), .NUM_TAGS(16), .MAX_PF_OUT(8), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .dem_cmd(dem_cmd), .dem_addr(dem_addr),
      .pf_cmd(pf_cmd), .pf_addr(pf_addr),
      .mem2arb_response(mem2arb_response), .mem2arb_tag(mem2arb_tag),
      .arb2mem_cmd(arb2mem_cmd), .arb2mem_addr(arb2mem_addr),
      .dem_response(dem_response), .pf_response(pf_response),
      .pf_bus_priority(pf_bus_priority),
      .data_is_dem(data_is_dem), .data_is_pf(data_is_pf),
      .pf_outstanding(pf_outstanding), .err_bad_tag(err_bad_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Inputs change just after the falling edge; combinational outputs are checked 1ns later.
   task automatic drive(input logic [1:0] dc, input logic [XL-1:0] da,
                        input logic [1:0] pc, input logic [XL-1:0] pa,
                        input logic [3:0] resp, input logic [3:0] tag);
      @(negedge clk);
      dem_cmd          = dc;
      dem_addr         = da;
      pf_cmd           = pc;
      pf_addr          = pa;
      mem2arb_response = resp;
      mem2arb_tag      = tag;
      #1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_pf_out", pf_outstanding, 0);
      check("rst_err", err_bad_tag, 0);
      check("rst_cmd", arb2mem_cmd, NONE);
      check("rst_addr", arb2mem_addr, 0);
      check("rst_dresp", dem_response, 0);
      check("rst_presp", pf_response, 0);
      check("rst_prio", pf_bus_priority, 0);
      check("rst_flags", {data_is_dem, data_is_pf}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // demand only, tag 3 accepted
      drive(LOAD, 64'h100, NONE, 0, 4'd3, 4'd0);
      check("t1_cmd", arb2mem_cmd, LOAD);
      check("t1_addr", arb2mem_addr, 64'h100);
      check("t1_dresp", dem_response, 3);
      check("t1_presp", pf_response, 0);
      check("t1_prio", pf_bus_priority, 0);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd3);
      check("t1_isdem", data_is_dem, 1);
      check("t1_ispf", data_is_pf, 0);

      // conflict: demand wins
      drive(LOAD, 64'h100, LOAD, 64'h200, 4'd5, 4'd0);
      check("t2_addr", arb2mem_addr, 64'h100);
      check("t2_dresp", dem_response, 5);
      check("t2_presp", pf_response, 0);
      check("t2_prio", pf_bus_priority, 1);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd5);
      check("t2_isdem", data_is_dem, 1);

      // held conflict: four rejected demand grants, fifth cycle accepts tag 7
      for (int i = 0; i < 4; i++) begin
         drive(LOAD, 64'h100, LOAD, 64'h200, 4'd0, 4'd0);
         check("t3_hold_addr", arb2mem_addr, 64'h100);
         check("t3_hold_prio", pf_bus_priority, 1);
      end
      drive(LOAD, 64'h100, LOAD, 64'h200, 4'd7, 4'd0);
`ifdef SYS_ARB_STARVE_GUARD_EN
      check("t3_force_addr", arb2mem_addr, 64'h200);
      check("t3_force_presp", pf_response, 7);
      check("t3_force_dresp", dem_response, 0);
      check("t3_force_prio", pf_bus_priority, 0);
      drive(LOAD, 64'h100, LOAD, 64'h200, 4'd0, 4'd0);
      check("t3_after_addr", arb2mem_addr, 64'h100);
      check("t3_pf_out1", pf_outstanding, 1);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd7);
      check("t3_ret_ispf", data_is_pf, 1);
`else
      check("t3_nog_addr", arb2mem_addr, 64'h100);
      check("t3_nog_dresp", dem_response, 7);
      check("t3_nog_presp", pf_response, 0);
      check("t3_nog_prio", pf_bus_priority, 1);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd7);
      check("t3_ret_isdem", data_is_dem, 1);
`endif

      // eight prefetch accepts, tags 1..8
      for (int i = 1; i <= 8; i++) begin
         drive(NONE, 0, LOAD, 64'h1000 + 64'(i * 8), 4'(i), 4'd0);
         check("t4_presp", pf_response, 64'(i));
         check("t4_prio", pf_bus_priority, 0);
      end
      drive(NONE, 0, LOAD, 64'h2000, 4'd9, 4'd0);
      check("t4_full_cnt", pf_outstanding, 8);
      check("t4_full_cmd", arb2mem_cmd, NONE);
      check("t4_full_presp", pf_response, 0);
      check("t4_full_prio", pf_bus_priority, 1);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd1);
      check("t4_ret1_ispf", data_is_pf, 1);
      drive(NONE, 0, LOAD, 64'h2000, 4'd1, 4'd2);
      check("t4_both_cnt_before", pf_outstanding, 7);
      check("t4_both_presp", pf_response, 1);
      check("t4_both_ispf", data_is_pf, 1);
      drive(NONE, 0, LOAD, 64'h2008, 4'd2, 4'd0);
      check("t4_both_cnt_after", pf_outstanding, 7);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd0);
      check("t4_refill_cnt", pf_outstanding, 8);

      // tag 3 completes as prefetch and is re-accepted by demand in the same cycle
      drive(LOAD, 64'h300, NONE, 0, 4'd3, 4'd3);
      check("t4_reuse_ispf", data_is_pf, 1);
      check("t4_reuse_isdem", data_is_dem, 0);
      check("t4_reuse_dresp", dem_response, 3);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd3);
      check("t4_reuse_cnt", pf_outstanding, 7);
      check("t4_reuse_ret_isdem", data_is_dem, 1);
      check("t4_reuse_ret_ispf", data_is_pf, 0);

      // unknown tag 9
      drive(NONE, 0, NONE, 0, 4'd0, 4'd9);
      check("t5_flags", {data_is_dem, data_is_pf}, 0);
      check("t5_err_pre", err_bad_tag, 0);
      check("t5_cnt", pf_outstanding, 7);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd0);
      check("t5_err_set", err_bad_tag, 1);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd0);
      check("t5_err_sticky", err_bad_tag, 1);

      // asynchronous reset mid-cycle with prefetch tags outstanding
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_cnt", pf_outstanding, 0);
      check("t6_rst_err", err_bad_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(NONE, 0, NONE, 0, 4'd0, 4'd4);
      check("t6_old_flags", {data_is_dem, data_is_pf}, 0);
      drive(NONE, 0, NONE, 0, 4'd0, 4'd0);
      check("t6_old_err", err_bad_tag, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
